// File: rtl/vga_fetch_scheduler_if.sv
// Host command/response and pixel-RAM bus of vga_fetch_scheduler.
// slave = the scheduler; master = the host plus RAM environment.
interface vga_fetch_scheduler_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 3
);
    logic              host_valid;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ready;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  host_valid, host_we, host_addr, host_wdata, mem_rdata,
        output host_ready, host_rvalid, host_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output host_valid, host_we, host_addr, host_wdata, mem_rdata,
        input  host_ready, host_rvalid, host_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vga_fetch_scheduler.sv
// Pixel prefetch FIFO + single-port RAM arbiter shared between display and host.
// Optional VGA_SCHED_STATS_EN adds host_stall_cnt (saturating host stall cycles).
module vga_fetch_scheduler #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 3,
    parameter int H_SIZE     = 800,
    parameter int V_SIZE     = 600,
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WM     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              pix_pop,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_underflow,
`ifdef VGA_SCHED_STATS_EN
    output logic [15:0]       host_stall_cnt,
`endif
    vga_fetch_scheduler_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CR_W  = CNT_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_SIZE * V_SIZE - 1);

    typedef enum logic [1:0] {IDLE, FETCH, FRAME_DONE} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] fetch_addr, fetch_addr_nxt;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              rd_vld_q, rd_disp_q;
    logic [DATA_W-1:0] rdata_q;
    logic [CR_W-1:0]   credit;
    logic              disp_fetch, host_gnt, push, pop, fifo_empty;

    assign fifo_empty = (fifo_cnt == '0);
    assign credit     = CR_W'(fifo_cnt) + CR_W'(rd_vld_q & rd_disp_q);

    // Arbitration: frame_start > urgent display > host > opportunistic display.
    always_comb begin
        disp_fetch = 1'b0;
        host_gnt   = 1'b0;
        if (frame_start)
            host_gnt = bus.host_valid;
        else if (state == FETCH && credit < CR_W'(LOW_WM))
            disp_fetch = 1'b1;
        else if (bus.host_valid)
            host_gnt = 1'b1;
        else if (state == FETCH && credit < CR_W'(FIFO_DEPTH))
            disp_fetch = 1'b1;
        if (!reset) begin
            disp_fetch = 1'b0;
            host_gnt   = 1'b0;
        end
    end

    assign bus.host_ready = host_gnt;
    assign bus.mem_en     = host_gnt | disp_fetch;
    assign bus.mem_we     = host_gnt & bus.host_we;
    assign bus.mem_addr   = host_gnt ? bus.host_addr : fetch_addr;
    assign bus.mem_wdata  = bus.host_wdata;

    always_comb begin
        state_nxt      = state;
        fetch_addr_nxt = fetch_addr;
        if (frame_start) begin
            state_nxt      = FETCH;
            fetch_addr_nxt = '0;
        end else if (disp_fetch) begin
            if (fetch_addr == LAST_ADDR) begin
                state_nxt      = FRAME_DONE;
                fetch_addr_nxt = '0;
            end else begin
                fetch_addr_nxt = fetch_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            fetch_addr <= '0;
        end else begin
            state      <= state_nxt;
            fetch_addr <= fetch_addr_nxt;
        end
    end

    // Tag pipe: one read in flight at most, tagged display vs host.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_vld_q  <= 1'b0;
            rd_disp_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rd_vld_q  <= bus.mem_en & ~bus.mem_we;
            rd_disp_q <= disp_fetch;
            if (bus.host_rvalid)
                rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.host_rvalid = rd_vld_q & ~rd_disp_q;
    assign bus.host_rdata  = bus.host_rvalid ? bus.mem_rdata : rdata_q;

    // A display return landing on frame_start belongs to the old frame.
    assign push = rd_vld_q & rd_disp_q & ~frame_start;
    assign pop  = pix_pop & ~fifo_empty;

    always_ff @(posedge clk) begin
        if (!reset || frame_start) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= bus.mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            pix_underflow <= 1'b0;
        else if (pix_pop && fifo_empty)
            pix_underflow <= 1'b1;
    end

    assign pix_data = (reset && !fifo_empty) ? fifo_mem[rd_ptr] : '0;

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        push |-> fifo_cnt != CNT_W'(FIFO_DEPTH));

`ifdef VGA_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset || frame_start)
            host_stall_cnt <= '0;
        else if (bus.host_valid && !host_gnt && host_stall_cnt != 16'hFFFF)
            host_stall_cnt <= host_stall_cnt + 1'b1;
    end
`endif
endmodule
